// File: rtl/pixel_fetch.sv
// Framebuffer scan-out fetcher: walks a frame in raster order, issues pixel reads
// to a fixed-latency memory and streams the returned pixels through a credit-limited FIFO.
module pixel_fetch #(
  parameter int H_PIX      = 64,
  parameter int V_LINES    = 64,
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       swap_req,
  input  logic [3:0] pixel,
  output logic [8:0] addr,
  output logic [2:0] pix_sel,
  output logic       bank,
  output logic       rd_issue,
  output logic [3:0] pix_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       pix_sof,
  output logic       pix_eol,
  output logic       busy
);

  localparam int          NPIX   = H_PIX * V_LINES;
  localparam int          XW     = $clog2(H_PIX);
  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [11:0] P_LAST = 12'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  typedef struct packed {
    logic [3:0] data;
    logic       sof;
    logic       eol;
  } ent_t;

  state_t              state;
  logic [11:0]         p;
  logic                swap_pend;
  logic                iss_sof, iss_eol;
  logic [READ_LAT-1:0] vld_pipe, sof_pipe, eol_pipe;
  ent_t                fifo [FIFO_DEPTH];
  ent_t                head;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic [3:0]          in_flight;
  logic [7:0]          outstanding;
  logic                push, pop, can_issue;

  assign push      = vld_pipe[READ_LAT-1];
  assign pix_valid = (count != '0);
  assign pop       = pix_valid & pix_ready;
  assign head      = fifo[rd_ptr];
  assign pix_data  = pix_valid ? head.data : 4'd0;
  assign pix_sof   = pix_valid & head.sof;
  assign pix_eol   = pix_valid & head.eol;
  assign busy      = (state != IDLE);

  // Requests on the bus this cycle plus those still in the return pipe.
  always_comb begin
    in_flight = 4'(rd_issue);
    for (int i = 0; i < READ_LAT; i++) in_flight = in_flight + 4'(vld_pipe[i]);
  end

  // A pop this cycle frees its slot in time for the next issue, which keeps
  // the stream at one pixel per cycle without ever overfilling the FIFO.
  assign outstanding = 8'(in_flight) + 8'(count) - 8'(pop);
  assign can_issue   = (state == FETCH) && (outstanding < 8'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      p         <= '0;
      addr      <= '0;
      pix_sel   <= '0;
      bank      <= 1'b0;
      swap_pend <= 1'b0;
      rd_issue  <= 1'b0;
      iss_sof   <= 1'b0;
      iss_eol   <= 1'b0;
      vld_pipe  <= '0;
      sof_pipe  <= '0;
      eol_pipe  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      rd_issue <= 1'b0;
      vld_pipe <= (vld_pipe << 1) | READ_LAT'(rd_issue);
      sof_pipe <= (sof_pipe << 1) | READ_LAT'(iss_sof);
      eol_pipe <= (eol_pipe << 1) | READ_LAT'(iss_eol);
      if (frame_start) begin
        // Restart drops everything in flight; late returns find an empty pipe.
        state     <= FETCH;
        p         <= '0;
        vld_pipe  <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        swap_pend <= 1'b0;
        if (swap_pend | swap_req) bank <= ~bank;
      end else begin
        if (swap_req) swap_pend <= 1'b1;
        case (state)
          FETCH: if (can_issue) begin
            rd_issue         <= 1'b1;
            {addr, pix_sel}  <= p;
            iss_sof          <= (p == '0);
            iss_eol          <= &p[XW-1:0];
            if (p == P_LAST) state <= DRAIN;
            else             p     <= p + 12'd1;
          end
          DRAIN: if (in_flight == '0 && count == '0) state <= IDLE;
          default: ;
        endcase
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  // Storage needs no reset: outputs are gated by pix_valid.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{data: pixel, sof: sof_pipe[READ_LAT-1], eol: eol_pipe[READ_LAT-1]};
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch: memory model returns p[3:0] two cycles after
// each issue; the stream is scored pixel by pixel and summarised per step.
module tb_pixel_fetch;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       frame_start = 1'b0, swap_req = 1'b0, pix_ready = 1'b0;
  logic [3:0] pixel, pix_data;
  logic [8:0] addr;
  logic [2:0] pix_sel;
  logic       bank, rd_issue, pix_valid, pix_sof, pix_eol, busy;
  logic [3:0] mp0, mp1;

  int tests = 0, fails = 0;
  int ready_pct = 100;
  int n_iss, n_pop, exp_idx, exp_addr, max_out, n_eol;
  int data_err, sof_err, eol_err, addr_err, hold_err;
  logic       last_pop_busy, prev_stall;
  logic [5:0] prev_out;

  always #5 clk = ~clk;

  pixel_fetch dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .swap_req(swap_req),
    .pixel(pixel), .addr(addr), .pix_sel(pix_sel), .bank(bank), .rd_issue(rd_issue),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy)
  );

  // Two-cycle read latency memory returning the low nibble of the pixel index.
  always @(posedge clk) begin
    if (rd_issue) mp0 <= {addr[0], pix_sel};
    mp1 <= mp0;
  end
  assign pixel = mp1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    n_iss = 0; n_pop = 0; exp_idx = 0; exp_addr = 0; max_out = 0; n_eol = 0;
    data_err = 0; sof_err = 0; eol_err = 0; addr_err = 0; hold_err = 0;
    prev_stall = 1'b0; last_pop_busy = 1'b0;
  endtask

  task automatic observe();
    if (rd_issue) begin
      if ({addr, pix_sel} !== 12'(exp_addr)) addr_err++;
      exp_addr++; n_iss++;
    end
    if (n_iss - n_pop > max_out) max_out = n_iss - n_pop;
    if (pix_valid && !pix_ready) begin
      if (prev_stall && {pix_data, pix_sof, pix_eol} !== prev_out) hold_err++;
      prev_stall = 1'b1;
      prev_out   = {pix_data, pix_sof, pix_eol};
    end else prev_stall = 1'b0;
    if (pix_valid && pix_ready) begin
      if (pix_data !== exp_idx[3:0]) data_err++;
      if (pix_sof !== (exp_idx == 0)) sof_err++;
      if (pix_eol !== (exp_idx[5:0] == 6'd63)) eol_err++;
      if (pix_eol) n_eol++;
      last_pop_busy = busy;
      exp_idx++; n_pop++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk); #1;
    frame_start = 1'b0;
    swap_req    = 1'b0;
    pix_ready   = ($urandom_range(99) < 32'(ready_pct));
  endtask

  task automatic start_frame(input logic swap);
    frame_start = 1'b1;
    swap_req    = swap;
    cycle();
    clear_exp();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_pops(input string tag, input int target, input int budget);
    int k = 0;
    while (n_pop < target && k < budget) begin cycle(); k++; end
    check(tag, n_pop >= target, 1);
  endtask

  task automatic run_issues(input string tag, input int target, input int budget);
    int k = 0;
    while (n_iss < target && k < budget) begin cycle(); k++; end
    check(tag, n_iss >= target, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 10) begin cycle(); k++; end
    check(tag, busy, 0);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_data"}, data_err, 0);
    check({tag, "_sof"},  sof_err,  0);
    check({tag, "_eol"},  eol_err,  0);
    check({tag, "_addr"}, addr_err, 0);
    check({tag, "_neol"}, n_eol,    64);
  endtask

  initial begin
    clear_exp();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {addr, pix_sel, bank, rd_issue, pix_data, pix_valid, pix_sof, pix_eol, busy}, 0);
    rst_n = 1'b1;
    run_cycles(5);
    check("idle_no_issue", n_iss, 0);
    check("idle_busy", busy, 0);

    // Full frame, downstream always ready
    ready_pct = 100;
    start_frame(1'b0);
    run_pops("t1_complete", 4096, 6000);
    check_stream("t1");
    check("t1_busy_at_last_pop", last_pop_busy, 1);
    wait_idle("t1_busy_falls");
    check("t1_no_extra_issue", n_iss, 4096);

    // Downstream stalled: credits cap the issues, head held steady
    ready_pct = 0;
    start_frame(1'b0);
    run_cycles(20);
    check("t2_issues", n_iss, 4);
    check("t2_valid", pix_valid, 1);
    check("t2_data", pix_data, 0);
    check("t2_sof", pix_sof, 1);
    check("t2_hold", hold_err, 0);
    ready_pct = 100;
    run_pops("t2_complete", 4096, 6000);
    check_stream("t2");
    check("t2_pops", n_pop, 4096);
    wait_idle("t2_idle");

    // Random 30% ready
    ready_pct = 30;
    start_frame(1'b0);
    run_pops("t3_complete", 4096, 20000);
    check_stream("t3");
    check("t3_credit", max_out <= 4, 1);
    check("t3_hold", hold_err, 0);
    ready_pct = 100;
    wait_idle("t3_idle");

    // Restart at pixel 1000: nothing old may leak into the new frame
    start_frame(1'b0);
    run_pops("t4_reach_1000", 1000, 2000);
    start_frame(1'b0);
    run_pops("t4_complete", 4096, 6000);
    check_stream("t4");
    wait_idle("t4_idle");
    check("t4_issues", n_iss, 4096);

    // Bank swap deferred to frame_start, and immediate with frame_start
    check("t5_bank_init", bank, 0);
    start_frame(1'b0);
    run_cycles(50);
    swap_req = 1'b1;
    cycle();
    run_cycles(50);
    check("t5_bank_hold", bank, 0);
    start_frame(1'b0);
    check("t5_bank_toggled", bank, 1);
    check("t5_before_first_req", n_iss, 0);
    run_issues("t5_first_issue", 1, 10);
    check("t5_bank_first_req", bank, 1);
    start_frame(1'b1);
    check("t5_bank_immediate", bank, 0);

    // Async reset in DRAIN with a swap pending
    run_issues("t6_reach_drain", 4096, 6000);
    swap_req = 1'b1;
    cycle();
    check("t6_in_drain", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_reset",
          {addr, pix_sel, bank, rd_issue, pix_data, pix_valid, pix_sof, pix_eol, busy}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_exp();
    run_cycles(10);
    check("t6_no_issue", n_iss, 0);
    check("t6_idle", busy, 0);
    start_frame(1'b0);
    check("t6_swap_cleared", bank, 0);
    run_issues("t6_restart", 1, 10);
    check("t6_addr", addr_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
